// File: rtl/lector_ram_audio_pkg.sv
// Shared definitions for the PSRAM audio reader: state encoding, bus widths
// and small helpers used by the read FSM.
package lector_ram_audio_pkg;

  // Width of the byte address coming from the address generator.
  localparam int ANCHO_DIR      = 26;
  // PSRAM word address and data widths.
  localparam int ANCHO_ADR_RAM  = 23;
  localparam int ANCHO_DATO_RAM = 16;
  // Width of one audio sample (one byte of the PSRAM word).
  localparam int ANCHO_MUESTRA  = 8;
  // Bit of the byte address that selects the upper or lower byte of a word.
  localparam int BIT_SEL_BYTE   = 0;
  // Cycle counter width; both timing parameters must fit in it.
  localparam int ANCHO_CONT     = 4;

  // Read FSM states.
  typedef enum logic [1:0] {
    REPOSO   = 2'd0,
    ACCESO   = 2'd1,
    RECUPERA = 2'd2
  } estado_t;

  // Clamp a cycle count into the 1..15 range the counter can represent,
  // so an out-of-range parameter never produces a zero-length phase.
  function automatic logic [ANCHO_CONT-1:0] limita_ciclos(input int unsigned ciclos);
    logic [ANCHO_CONT-1:0] res;
    if (ciclos < 1) begin
      res = 4'd1;
    end else if (ciclos > 15) begin
      res = 4'd15;
    end else begin
      res = ANCHO_CONT'(ciclos);
    end
    return res;
  endfunction

  // Pick the addressed byte out of a PSRAM word: odd addresses use the
  // upper byte, even addresses the lower byte.
  function automatic logic [ANCHO_MUESTRA-1:0] selecciona_byte(
    input logic [ANCHO_DATO_RAM-1:0] palabra,
    input logic                      sel
  );
    return sel ? palabra[15:8] : palabra[7:0];
  endfunction

endpackage

// File: rtl/lector_ram_audio.sv
// Single asynchronous read from a 16-bit cellular PSRAM per request strobe.
// Latches the word address, holds CE_n/OE_n low for CICLOS_ACCESO cycles,
// captures the word and the addressed byte, then keeps CE_n high for
// CICLOS_RECUPERACION cycles before accepting the next request.
module lector_ram_audio
  import lector_ram_audio_pkg::*;
#(
  parameter int unsigned CICLOS_ACCESO       = 4,
  parameter int unsigned CICLOS_RECUPERACION = 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [ANCHO_DIR-1:0]      DireccionRAM,
  input  logic                      solicitud,
  output logic                      ocupado,
  output logic [ANCHO_MUESTRA-1:0]  muestra,
  output logic [ANCHO_DATO_RAM-1:0] dato,
  output logic                      dato_valido,
  output logic                      solicitud_perdida,
  output logic [ANCHO_ADR_RAM-1:0]  ram_adr,
  input  logic [ANCHO_DATO_RAM-1:0] ram_dq,
  output logic                      ram_ce_n,
  output logic                      ram_oe_n,
  output logic                      ram_we_n,
  output logic                      ram_adv_n,
  output logic                      ram_lb_n,
  output logic                      ram_ub_n,
  output logic                      ram_cre,
  output logic                      ram_clk,
  output logic                      flash_ce_n
);

  // Phase lengths as counter values; the counter counts 1..N within a phase.
  localparam logic [ANCHO_CONT-1:0] LIM_ACCESO = limita_ciclos(CICLOS_ACCESO);
  localparam logic [ANCHO_CONT-1:0] LIM_RECUP  = limita_ciclos(CICLOS_RECUPERACION);

  estado_t                   estado_reg, estado_next;
  logic [ANCHO_CONT-1:0]     contador_reg, contador_next;
  logic [ANCHO_ADR_RAM-1:0]  adr_reg, adr_next;
  logic                      sel_reg, sel_next;
  logic                      ce_n_reg, ce_n_next;
  logic                      oe_n_reg, oe_n_next;
  logic [ANCHO_DATO_RAM-1:0] dato_reg, dato_next;
  logic [ANCHO_MUESTRA-1:0]  muestra_reg, muestra_next;
  logic                      valido_reg, valido_next;
  logic                      perdida_reg, perdida_next;

  // Address bits above the 16 MB PSRAM window are deliberately dropped.
  logic bits_altos_unused;
  assign bits_altos_unused = ^DireccionRAM[ANCHO_DIR-1:ANCHO_ADR_RAM+1];

  // State and output registers; reset aborts any access in progress.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      estado_reg   <= REPOSO;
      contador_reg <= '0;
      adr_reg      <= '0;
      sel_reg      <= 1'b0;
      ce_n_reg     <= 1'b1;
      oe_n_reg     <= 1'b1;
      dato_reg     <= '0;
      muestra_reg  <= '0;
      valido_reg   <= 1'b0;
      perdida_reg  <= 1'b0;
    end else begin
      estado_reg   <= estado_next;
      contador_reg <= contador_next;
      adr_reg      <= adr_next;
      sel_reg      <= sel_next;
      ce_n_reg     <= ce_n_next;
      oe_n_reg     <= oe_n_next;
      dato_reg     <= dato_next;
      muestra_reg  <= muestra_next;
      valido_reg   <= valido_next;
      perdida_reg  <= perdida_next;
    end
  end

  // Next-state logic: accept in REPOSO, time the access, then the recovery gap.
  always_comb begin
    estado_next   = estado_reg;
    contador_next = contador_reg;
    adr_next      = adr_reg;
    sel_next      = sel_reg;
    ce_n_next     = ce_n_reg;
    oe_n_next     = oe_n_reg;
    dato_next     = dato_reg;
    muestra_next  = muestra_reg;
    valido_next   = 1'b0;
    perdida_next  = 1'b0;

    case (estado_reg)
      REPOSO: begin
        if (solicitud) begin
          // The address is captured only here; later changes are ignored.
          adr_next      = DireccionRAM[ANCHO_ADR_RAM:1];
          sel_next      = DireccionRAM[BIT_SEL_BYTE];
          ce_n_next     = 1'b0;
          oe_n_next     = 1'b0;
          contador_next = 4'd1;
          estado_next   = ACCESO;
        end
      end

      ACCESO: begin
        perdida_next = solicitud;
        if (contador_reg == LIM_ACCESO) begin
          // Data has been valid on the bus for at least tAA: capture it.
          dato_next     = ram_dq;
          muestra_next  = selecciona_byte(ram_dq, sel_reg);
          valido_next   = 1'b1;
          ce_n_next     = 1'b1;
          oe_n_next     = 1'b1;
          contador_next = 4'd1;
          estado_next   = RECUPERA;
        end else begin
          contador_next = contador_reg + 4'd1;
        end
      end

      RECUPERA: begin
        perdida_next = solicitud;
        if (contador_reg == LIM_RECUP) begin
          contador_next = '0;
          estado_next   = REPOSO;
        end else begin
          contador_next = contador_reg + 4'd1;
        end
      end

      default: begin
        // Unreachable encoding: park the chip deselected and go idle.
        ce_n_next     = 1'b1;
        oe_n_next     = 1'b1;
        contador_next = '0;
        estado_next   = REPOSO;
      end
    endcase
  end

  assign ocupado           = (estado_reg != REPOSO);
  assign muestra           = muestra_reg;
  assign dato              = dato_reg;
  assign dato_valido       = valido_reg;
  assign solicitud_perdida = perdida_reg;
  assign ram_adr           = adr_reg;
  assign ram_ce_n          = ce_n_reg;
  assign ram_oe_n          = oe_n_reg;

  // Fixed PSRAM/flash pins: asynchronous read-only word access, flash off.
  assign ram_we_n   = 1'b1;
  assign ram_adv_n  = 1'b0;
  assign ram_lb_n   = 1'b0;
  assign ram_ub_n   = 1'b0;
  assign ram_cre    = 1'b0;
  assign ram_clk    = 1'b0;
  assign flash_ce_n = 1'b1;

endmodule

// File: tb/tb_lector_ram_audio.sv
// Bench for lector_ram_audio: directed and random requests checked every
// cycle against a timeline model based on acceptance edges.
module tb_lector_ram_audio;

  localparam int A = 4;
  localparam int R = 1;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [25:0] DireccionRAM;
  logic        solicitud;
  logic        ocupado;
  logic [7:0]  muestra;
  logic [15:0] dato;
  logic        dato_valido;
  logic        solicitud_perdida;
  logic [22:0] ram_adr;
  logic [15:0] ram_dq;
  logic        ram_ce_n, ram_oe_n, ram_we_n, ram_adv_n, ram_lb_n, ram_ub_n;
  logic        ram_cre, ram_clk, flash_ce_n;

  lector_ram_audio #(
    .CICLOS_ACCESO(A),
    .CICLOS_RECUPERACION(R)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .DireccionRAM(DireccionRAM),
    .solicitud(solicitud),
    .ocupado(ocupado),
    .muestra(muestra),
    .dato(dato),
    .dato_valido(dato_valido),
    .solicitud_perdida(solicitud_perdida),
    .ram_adr(ram_adr),
    .ram_dq(ram_dq),
    .ram_ce_n(ram_ce_n),
    .ram_oe_n(ram_oe_n),
    .ram_we_n(ram_we_n),
    .ram_adv_n(ram_adv_n),
    .ram_lb_n(ram_lb_n),
    .ram_ub_n(ram_ub_n),
    .ram_cre(ram_cre),
    .ram_clk(ram_clk),
    .flash_ce_n(flash_ce_n)
  );

  always #10 clk = ~clk;

  // PSRAM model: drives a word only while both CE_n and OE_n are low.
  logic [15:0] palabra [64];
  always_comb begin
    ram_dq = 16'hDEAD;
    if (!ram_ce_n && !ram_oe_n) ram_dq = palabra[ram_adr[5:0]];
  end

  int errors = 0;
  int checks = 0;

  // Reference timeline: e0 = edge of the current acceptance, libre = first
  // edge at which a new request may be accepted.
  int          n = 0;
  int          e0 = -1000;
  int          libre = 0;
  logic [22:0] adr_exp = '0;
  logic        sel_exp = 1'b0;
  logic [15:0] dato_exp = '0;
  logic [7:0]  muestra_exp = '0;
  logic        perd_exp = 1'b0;
  int          aceptadas = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] esp);
    checks++;
    assert (obs === esp) else begin
      errors++;
      $display("FAIL %s observed=%h expected=%h (edge %0d)", tag, obs, esp, n);
      $error("check %s", tag);
    end
  endtask

  // One clock edge: update the model from the applied inputs, then compare.
  task automatic paso();
    @(posedge clk);
    n++;
    if (!rst_n) begin
      e0          = -1000;
      libre       = n + 1;
      adr_exp     = '0;
      sel_exp     = 1'b0;
      dato_exp    = '0;
      muestra_exp = '0;
      perd_exp    = 1'b0;
    end else begin
      perd_exp = 1'b0;
      if (solicitud) begin
        if (n >= libre) begin
          e0      = n;
          adr_exp = DireccionRAM[23:1];
          sel_exp = DireccionRAM[0];
          libre   = n + A + R + 1;
          aceptadas++;
        end else begin
          perd_exp = 1'b1;
        end
      end
      if (n == e0 + A) begin
        dato_exp    = palabra[adr_exp[5:0]];
        muestra_exp = sel_exp ? dato_exp[15:8] : dato_exp[7:0];
      end
    end
    #1;
    chk("ocupado", 32'(ocupado), 32'(n >= e0 && n < e0 + A + R));
    chk("ram_ce_n", 32'(ram_ce_n), 32'(!(n >= e0 && n < e0 + A)));
    chk("ram_oe_n", 32'(ram_oe_n), 32'(!(n >= e0 && n < e0 + A)));
    chk("ram_adr", 32'(ram_adr), 32'(adr_exp));
    chk("dato_valido", 32'(dato_valido), 32'(rst_n && n == e0 + A));
    chk("solicitud_perdida", 32'(solicitud_perdida), 32'(perd_exp));
    chk("dato", 32'(dato), 32'(dato_exp));
    chk("muestra", 32'(muestra), 32'(muestra_exp));
    chk("static_pins",
        32'({ram_we_n, flash_ce_n, ram_adv_n, ram_lb_n, ram_ub_n, ram_cre, ram_clk}),
        32'(7'b1100000));
  endtask

  task automatic pedir(input logic [25:0] dir, input int espera);
    DireccionRAM = dir;
    solicitud    = 1'b1;
    paso();
    solicitud    = 1'b0;
    for (int i = 0; i < espera; i++) paso();
  endtask

  initial begin
    for (int i = 0; i < 64; i++) palabra[i] = 16'($urandom);
    rst_n        = 1'b0;
    solicitud    = 1'b0;
    DireccionRAM = '0;

    // Reset state.
    for (int i = 0; i < 3; i++) paso();
    rst_n = 1'b1;
    paso();

    // Even address: lower byte.
    palabra[8] = 16'hA55A;
    pedir(26'h0000010, 7);
    chk("even_dato", 32'(dato), 32'h0000A55A);
    chk("even_muestra", 32'(muestra), 32'h0000005A);

    // Odd address: upper byte.
    palabra[9] = 16'h1234;
    pedir(26'h0000013, 7);
    chk("odd_muestra", 32'(muestra), 32'h00000012);

    // Address change mid-access must not move ram_adr.
    palabra[6'h38] = 16'hBEEF;
    DireccionRAM = 26'h0A17FF0;
    solicitud    = 1'b1;
    paso();
    solicitud    = 1'b0;
    DireccionRAM = 26'h1234567;
    for (int i = 0; i < 7; i++) begin
      paso();
      DireccionRAM = 26'($urandom);
    end
    chk("midchange_adr", 32'(ram_adr), 32'h00050BFF8 & 32'h007FFFFF);
    chk("midchange_dato", 32'(dato), 32'h0000BEEF);

    // Address wrap: upper bits discarded.
    palabra[63] = 16'hC3A5;
    pedir(26'h3FFFFFF, 7);
    chk("wrap_adr", 32'(ram_adr), 32'h007FFFFF);
    chk("wrap_muestra", 32'(muestra), 32'h000000C3);

    // Reset in the middle of an access.
    DireccionRAM = 26'h0000456;
    solicitud    = 1'b1;
    paso();
    solicitud    = 1'b0;
    paso();
    rst_n = 1'b0;
    paso();
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) paso();

    // Back-to-back: solicitud held high for 20 cycles.
    aceptadas = 0;
    solicitud = 1'b1;
    for (int i = 0; i < 20; i++) begin
      DireccionRAM = 26'($urandom);
      paso();
    end
    solicitud = 1'b0;
    for (int i = 0; i < 8; i++) paso();

    // Random traffic with occasional resets and memory updates.
    for (int i = 0; i < 400; i++) begin
      solicitud    = ($urandom_range(0, 99) < 35);
      DireccionRAM = 26'($urandom);
      rst_n        = ($urandom_range(0, 199) != 0);
      if ($urandom_range(0, 3) == 0) palabra[$urandom_range(0, 63)] = 16'($urandom);
      paso();
    end
    rst_n     = 1'b1;
    solicitud = 1'b0;
    for (int i = 0; i < 8; i++) paso();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/lector_ram_audio.md
Name: lector_ram_audio

Overview:
- Downstream consumer of the RAM address generator.
- Takes the 26-bit byte address and a one-cycle request strobe, then performs one asynchronous read on the external 16-bit cellular PSRAM.
- Returns the addressed 8-bit audio sample and the full 16-bit word, with a one-cycle valid pulse.
- Sits between the address generator and the audio/playback logic; keeps the shared flash chip deselected.

Parameters:
- CICLOS_ACCESO, 4, clk cycles CE_n/OE_n held low before data capture (4 × 20 ns ≥ 70 ns tAA at 50 MHz); legal range 1..15.
- CICLOS_RECUPERACION, 1, idle cycles with CE_n high between accesses (tCPH); legal range 1..15.

Ports:
- clk  in  1  system clock, 50 MHz.
- rst_n  in  1  synchronous active-low reset.
- DireccionRAM  in  26  byte address from the address generator; bit 0 selects the byte; bits [25:24] ignored.
- solicitud  in  1  one-cycle read request, sampled on rising clk.
- ocupado  out  1  high whenever state != REPOSO.
- muestra  out  8  selected byte of the last word read.
- dato  out  16  full last word read.
- dato_valido  out  1  one-cycle pulse when muestra/dato update.
- solicitud_perdida  out  1  one-cycle pulse when solicitud arrives while ocupado.
- ram_adr  out  23  word address to PSRAM (DireccionRAM[23:1]).
- ram_dq  in  16  PSRAM data bus (read-only use).
- ram_ce_n, ram_oe_n  out  1  chip enable / output enable, active low.
- ram_we_n  out  1  constant 1.
- ram_adv_n  out  1  constant 0 (asynchronous mode).
- ram_lb_n, ram_ub_n  out  1  constant 0.
- ram_cre  out  1  constant 0.
- ram_clk  out  1  constant 0.
- flash_ce_n  out  1  constant 1.

Behaviour:
- All outputs are registered except ocupado, which is decoded from state.
- Reset (rst_n=0 at a rising edge), from any state including mid-access:
  - state=REPOSO, ram_ce_n=ram_oe_n=1, ram_adr=0.
  - dato=0, muestra=0, dato_valido=0, solicitud_perdida=0.
  - counter=0, latched byte-select=0.
- FSM states: REPOSO, ACCESO, RECUPERA.
- REPOSO:
  - If solicitud=1 at edge E0: latch ram_adr<=DireccionRAM[23:1] and sel<=DireccionRAM[0]; ram_ce_n<=0, ram_oe_n<=0; counter<=1; go to ACCESO.
- ACCESO:
  - Hold ram_adr stable; counter increments each edge.
  - At edge E0+CICLOS_ACCESO: dato<=ram_dq; muestra<= sel ? ram_dq[15:8] : ram_dq[7:0]; dato_valido<=1; ram_ce_n<=1, ram_oe_n<=1; counter<=1; go to RECUPERA.
- RECUPERA:
  - At edge E0+CICLOS_ACCESO+CICLOS_RECUPERACION: go to REPOSO.
- Latency:
  - dato_valido is high exactly during the cycle following edge E0+CICLOS_ACCESO; it is 0 in every other cycle.
  - Next request is accepted no earlier than edge E0+CICLOS_ACCESO+CICLOS_RECUPERACION+1 (defaults: 6-cycle period, 120 ns).
- solicitud while ocupado=1: ignored, no address latch; solicitud_perdida<=1 for one cycle. A held-high solicitud is accepted again once the state is REPOSO.
- DireccionRAM changing during ACCESO has no effect; the address is latched only at acceptance.
- dato and muestra hold their last values until the next capture.
- Address wrap (e.g. 26'h3FFFFFF) is truncated to [23:1]; no error is flagged.

Decomposition:
- Shared package holds:
  - state encoding localparams REPOSO/ACCESO/RECUPERA.
  - PSRAM width constants ANCHO_ADR_RAM=23, ANCHO_DATO_RAM=16.
  - byte-select bit index.
- No sub-module is needed; a single FSM with a 4-bit counter suffices.

Test Plan:
- Reset mid-access: request, then drop rst_n at E0+2 -> next edge shows ram_ce_n=1, ram_oe_n=1, ocupado=0, dato=0, no dato_valido.
- Even address: DireccionRAM=26'h0000010, ram_dq model=16'hA55A, solicitud at E0 -> ram_adr=23'h000008; ram_ce_n low for exactly 4 cycles; dato_valido only after E0+4; dato=16'hA55A, muestra=8'h5A.
- Odd address: DireccionRAM=26'h0000013, ram_dq=16'h1234 -> ram_adr=23'h000009, muestra=8'h12.
- Back-to-back: solicitud held high for 20 cycles -> acceptances at E0, E0+6, E0+12, E0+18; solicitud_perdida pulses on the cycles between acceptances.
- Address change mid-access: request at 26'h0A17FF0, DireccionRAM changed at E0+1 -> ram_adr stays 23'h050BFF8 through capture.
- Static pins: whole run -> ram_we_n=1, flash_ce_n=1, ram_adv_n=0, ram_lb_n=ram_ub_n=0, ram_cre=0, ram_clk=0 at every cycle.
